// File: rtl/cpu_clk_ctrl_pkg.sv
// Shared encodings for the CPU clock-enable controller: run-mode codes, FSM states
// and small helpers used by the controller and its interface.
package cpu_clk_pkg;

    localparam logic [1:0] MODE_HALT  = 2'b00;
    localparam logic [1:0] MODE_RUN   = 2'b01;
    localparam logic [1:0] MODE_STEP  = 2'b10;
    localparam logic [1:0] MODE_BURST = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_RUN       = 2'b01,
        ST_STEP_WAIT = 2'b10,
        ST_BURST     = 2'b11
    } state_t;

    function automatic logic is_busy(input state_t st);
        return (st == ST_STEP_WAIT) || (st == ST_BURST);
    endfunction

endpackage

// File: rtl/cpu_clk_ctrl_if.sv
// Control/status bundle between a debug front end (master) and cpu_clk_ctrl (slave).
// CycleCount exists only when CPU_CLK_CTRL_CYCLE_COUNT_EN is defined.
interface cpu_clk_ctrl_if #(
    parameter int BURST_W = 16
);
    logic [1:0]         Mode;
    logic               Step;
    logic               Start;
    logic [BURST_W-1:0] BurstLen;
    logic               CpuEn;
    logic               Busy;
    logic               Done;
    logic [BURST_W-1:0] Remaining;
`ifdef CPU_CLK_CTRL_CYCLE_COUNT_EN
    logic [31:0]        CycleCount;

    modport master (
        output Mode, Step, Start, BurstLen,
        input  CpuEn, Busy, Done, Remaining, CycleCount
    );

    modport slave (
        input  Mode, Step, Start, BurstLen,
        output CpuEn, Busy, Done, Remaining, CycleCount
    );
`else
    modport master (
        output Mode, Step, Start, BurstLen,
        input  CpuEn, Busy, Done, Remaining
    );

    modport slave (
        input  Mode, Step, Start, BurstLen,
        output CpuEn, Busy, Done, Remaining
    );
`endif
endinterface

// File: rtl/cpu_clk_ctrl_sync_edge_det.sv
// Multi-stage synchroniser for an asynchronous level followed by a registered
// rising-edge detector; the pulse appears SYNC_STAGES+1 clocks after the input edge.
module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic pulse
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   prev_r;
    logic                   pulse_r;

    // Synchroniser chain, previous-value register and edge pulse register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r  <= {SYNC_STAGES{1'b0}};
            prev_r  <= 1'b0;
            pulse_r <= 1'b0;
        end else begin
            sync_r  <= {sync_r[SYNC_STAGES-2:0], async_in};
            prev_r  <= sync_r[SYNC_STAGES-1];
            pulse_r <= sync_r[SYNC_STAGES-1] & ~prev_r;
        end
    end

    assign pulse = pulse_r;

endmodule

// File: rtl/cpu_clk_ctrl.sv
// Clock-enable controller for the CPU core: one-cycle CpuEn strobes every DIV clocks,
// with halt / run / single-step / N-cycle burst modes. Optional CycleCount output
// is enabled by defining CPU_CLK_CTRL_CYCLE_COUNT_EN.
module cpu_clk_ctrl
    import cpu_clk_pkg::*;
#(
    parameter int DIV         = 4,
    parameter int BURST_W     = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic          Clock,
    input  logic          Resetn,
    cpu_clk_ctrl_if.slave bus
);

    localparam int              PW       = 16;
    localparam logic [PW-1:0]   DIV_LAST = PW'(DIV - 1);
    localparam logic [BURST_W-1:0] REM_ZERO = BURST_W'(0);
    localparam logic [BURST_W-1:0] REM_ONE  = BURST_W'(1);

    logic               step_pulse_s;
    logic               start_pulse_s;
    logic [PW-1:0]      presc_r;
    logic               tick_s;
    state_t             state_r;
    state_t             state_nx;
    logic               cpu_en_nx;
    logic               done_nx;
    logic [BURST_W-1:0] remaining_nx;
    logic               cpu_en_r;
    logic               busy_r;
    logic               done_r;
    logic [BURST_W-1:0] remaining_r;

    sync_edge_det #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_step_sync (
        .clk      (Clock),
        .rst_n    (Resetn),
        .async_in (bus.Step),
        .pulse    (step_pulse_s)
    );

    sync_edge_det #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_start_sync (
        .clk      (Clock),
        .rst_n    (Resetn),
        .async_in (bus.Start),
        .pulse    (start_pulse_s)
    );

    assign tick_s = (presc_r == DIV_LAST);

    // Prescaler: zero on every entry to an active state so the first tick lands DIV clocks in
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            presc_r <= 16'd0;
        end else if ((state_r == ST_IDLE) || (state_nx == ST_IDLE)) begin
            presc_r <= 16'd0;
        end else if (tick_s) begin
            presc_r <= 16'd0;
        end else begin
            presc_r <= presc_r + 16'd1;
        end
    end

    // State register
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // Next-state and next-output decode; a Mode mismatch in any active state aborts silently
    always_comb begin
        state_nx     = state_r;
        cpu_en_nx    = 1'b0;
        done_nx      = 1'b0;
        remaining_nx = remaining_r;
        case (state_r)
            ST_IDLE: begin
                remaining_nx = REM_ZERO;
                if (bus.Mode == MODE_RUN) begin
                    state_nx = ST_RUN;
                end else if ((bus.Mode == MODE_STEP) && step_pulse_s) begin
                    state_nx = ST_STEP_WAIT;
                end else if ((bus.Mode == MODE_BURST) && start_pulse_s) begin
                    if (bus.BurstLen != REM_ZERO) begin
                        state_nx     = ST_BURST;
                        remaining_nx = bus.BurstLen;
                    end else begin
                        done_nx = 1'b1;
                    end
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (bus.Mode != MODE_RUN) begin
                    state_nx = ST_IDLE;
                end else begin
                    cpu_en_nx = tick_s;
                end
            end
            ST_STEP_WAIT: begin
                if (bus.Mode != MODE_STEP) begin
                    state_nx = ST_IDLE;
                end else if (tick_s) begin
                    cpu_en_nx = 1'b1;
                    done_nx   = 1'b1;
                    state_nx  = ST_IDLE;
                end else begin
                    state_nx = ST_STEP_WAIT;
                end
            end
            ST_BURST: begin
                if (bus.Mode != MODE_BURST) begin
                    state_nx     = ST_IDLE;
                    remaining_nx = REM_ZERO;
                end else if (tick_s) begin
                    cpu_en_nx = 1'b1;
                    if (remaining_r <= REM_ONE) begin
                        remaining_nx = REM_ZERO;
                        done_nx      = 1'b1;
                        state_nx     = ST_IDLE;
                    end else begin
                        remaining_nx = remaining_r - REM_ONE;
                    end
                end else begin
                    state_nx = ST_BURST;
                end
            end
            default: begin
                state_nx     = ST_IDLE;
                remaining_nx = REM_ZERO;
            end
        endcase
    end

    // Registered outputs
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            cpu_en_r    <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            remaining_r <= REM_ZERO;
        end else begin
            cpu_en_r    <= cpu_en_nx;
            busy_r      <= is_busy(state_nx);
            done_r      <= done_nx;
            remaining_r <= remaining_nx;
        end
    end

    assign bus.CpuEn     = cpu_en_r;
    assign bus.Busy      = busy_r;
    assign bus.Done      = done_r;
    assign bus.Remaining = remaining_r;

`ifdef CPU_CLK_CTRL_CYCLE_COUNT_EN
    logic [31:0] cycle_cnt_r;

    // Enable counter, updated together with CpuEn so it always equals the pulses issued
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            cycle_cnt_r <= 32'd0;
        end else if (cpu_en_nx) begin
            cycle_cnt_r <= cycle_cnt_r + 32'd1;
        end else begin
            cycle_cnt_r <= cycle_cnt_r;
        end
    end

    assign bus.CycleCount = cycle_cnt_r;
`endif

endmodule
